// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle word data memory on the responder side of a valid/ready
//   load/store interface. One request is accepted at a time from IDLE, held
//   in BUSY for LATENCY edges, then the access is done and the response is
//   presented in RESP until the requester takes it.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready : request handshake (ready only in IDLE)
//   req_wr                : 1 = store, 0 = load
//   req_addr              : byte address, word index = req_addr[ADDR_WIDTH:1]
//   req_data              : store data
//   resp_valid/resp_ready : response handshake (valid only in RESP)
//   resp_data             : load data, or the stored data for a store
//   resp_err              : misaligned request, no access performed
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_err
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam int         DEPTH    = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Latched request; only the word index and the alignment bit matter, the
  // upper address bits alias away.
  logic                  lat_wr;
  logic                  lat_odd;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [15:0]           lat_data;

  logic [15:0] mem [DEPTH];

  logic accept, done, mem_we;
  logic unused_addr;

  assign unused_addr = ^req_addr;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  assign accept = req_valid && (state == S_IDLE);
  assign done   = (state == S_BUSY) && (cnt == 4'd0);
  // Gated by state, so an async reset during BUSY kills the pending store.
  assign mem_we = done && lat_wr && !lat_odd;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (req_valid) begin
        state_nxt = S_BUSY;
        cnt_nxt   = CNT_INIT;
      end
      S_BUSY: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
              else             state_nxt = S_RESP;
      S_RESP: if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_wr    <= 1'b0;
      lat_odd   <= 1'b0;
      lat_idx   <= '0;
      lat_data  <= 16'h0000;
      resp_data <= 16'h0000;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_wr   <= req_wr;
        lat_odd  <= req_addr[0];
        lat_idx  <= req_addr[ADDR_WIDTH:1];
        lat_data <= req_data;
      end
      if (done) begin
        if (lat_odd) begin
          resp_err  <= 1'b1;
          resp_data <= 16'h0000;
        end else begin
          resp_err  <= 1'b0;
          // Load returns the pre-edge contents.
          resp_data <= lat_wr ? lat_data : mem[lat_idx];
        end
      end
    end
  end

  // Storage is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[lat_idx] <= lat_data;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: LATENCY 4
  logic        req_valid0, req_ready0, req_wr0, resp_valid0, resp_ready0, resp_err0;
  logic [15:0] req_addr0, req_data0, resp_data0;
  // Instance 1: LATENCY 1
  logic        req_valid1, req_ready1, req_wr1, resp_valid1, resp_ready1, resp_err1;
  logic [15:0] req_addr1, req_data1, resp_data1;

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_wr(req_wr0),
    .req_addr(req_addr0), .req_data(req_data0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_data(resp_data0), .resp_err(resp_err0)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
    .req_addr(req_addr1), .req_data(req_data1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_data(resp_data1), .resp_err(resp_err1)
  );

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the falling edge; monitors sample 2 after.
  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop on the cycle a handshake will occur.
  logic prev_rv0 = 1'b0, prev_rv1 = 1'b0;
  int   rise0 = 0, rise1 = 0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) prev_rv0 = 1'b0;
    else begin
      if (resp_valid0 && !prev_rv0) rise0 = cyc;
      prev_rv0 = resp_valid0;
      if (resp_valid0 && resp_ready0) begin
        if (sb0.size() == 0) chk("resp0_unexpected", 32'd0, 32'd1);
        else begin
          exp_t e;
          e = sb0.pop_front();
          chk("resp0_data", resp_data0, e.data);
          chk("resp0_err", resp_err0, e.err);
          chk("resp0_latency", rise0 - e.acc, LAT0);
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst_n) prev_rv1 = 1'b0;
    else begin
      if (resp_valid1 && !prev_rv1) rise1 = cyc;
      prev_rv1 = resp_valid1;
      if (resp_valid1 && resp_ready1) begin
        if (sb1.size() == 0) chk("resp1_unexpected", 32'd0, 32'd1);
        else begin
          exp_t e;
          e = sb1.pop_front();
          chk("resp1_data", resp_data1, e.data);
          chk("resp1_err", resp_err1, e.err);
          chk("resp1_latency", rise1 - e.acc, LAT1);
        end
      end
    end
  end

  // Full transaction on instance 0 with resp_ready already high.
  task automatic do_req0(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                         input logic [15:0] exp_d, input logic exp_e);
    int t;
    nedge();
    chk("rdy0_before", req_ready0, 1'b1);
    req_wr0 = wr; req_addr0 = addr; req_data0 = data; req_valid0 = 1'b1;
    sb0.push_back('{data: exp_d, err: exp_e, acc: cyc + 1});
    nedge();
    req_valid0 = 1'b0;
    chk("rdy0_fall", req_ready0, 1'b0);
    t = 0;
    while (sb0.size() != 0 && t < 50) begin
      nedge();
      t++;
    end
    chk("resp0_timeout", sb0.size(), 0);
    nedge();
    chk("rdy0_back", req_ready0, 1'b1);
    chk("rv0_one_cycle", resp_valid0, 1'b0);
  endtask

  initial begin
    int t, k, prev_acc;
    logic [15:0] a, d, ed;
    logic w, ee;

    rst_n = 1'b0;
    req_valid0 = 0; req_wr0 = 0; req_addr0 = 0; req_data0 = 0; resp_ready0 = 1;
    req_valid1 = 0; req_wr1 = 0; req_addr1 = 0; req_data1 = 0; resp_ready1 = 1;
    #2;
    chk("rst_req_ready", req_ready0, 1'b1);
    chk("rst_resp_valid", resp_valid0, 1'b0);
    chk("rst_resp_data", resp_data0, 16'h0000);
    chk("rst_resp_err", resp_err0, 1'b0);
    repeat (2) nedge();
    rst_n = 1'b1;

    // Basic store/load and aliasing
    do_req0(1'b1, 16'h0020, 16'h5555, 16'h5555, 1'b0);
    do_req0(1'b1, 16'h0010, 16'hBEEF, 16'hBEEF, 1'b0);
    do_req0(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    do_req0(1'b0, 16'h0210, 16'h0000, 16'hBEEF, 1'b0);
    // Misaligned store performs nothing
    do_req0(1'b1, 16'h0011, 16'h1234, 16'h0000, 1'b1);
    do_req0(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

    // Response back-pressure; requests offered meanwhile must be ignored
    nedge();
    resp_ready0 = 1'b0;
    req_wr0 = 1'b0; req_addr0 = 16'h0010; req_valid0 = 1'b1;
    sb0.push_back('{data: 16'hBEEF, err: 1'b0, acc: cyc + 1});
    nedge();
    req_valid0 = 1'b0;
    t = 0;
    while (!resp_valid0 && t < 50) begin
      nedge();
      t++;
    end
    chk("stall_timeout", resp_valid0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rv", resp_valid0, 1'b1);
      chk("stall_data", resp_data0, 16'hBEEF);
      chk("stall_err", resp_err0, 1'b0);
      chk("stall_rdy", req_ready0, 1'b0);
      req_wr0 = 1'b1; req_addr0 = 16'h0010; req_data0 = 16'hDEAD; req_valid0 = 1'b1;
      nedge();
    end
    req_valid0 = 1'b0;
    resp_ready0 = 1'b1;
    nedge();
    chk("stall_done_rv", resp_valid0, 1'b0);
    chk("stall_done_sb", sb0.size(), 0);
    do_req0(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

    // Reset in the middle of a store
    nedge();
    req_wr0 = 1'b1; req_addr0 = 16'h0020; req_data0 = 16'hAAAA; req_valid0 = 1'b1;
    nedge();
    req_valid0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready0, 1'b1);
    chk("midrst_resp_valid", resp_valid0, 1'b0);
    chk("midrst_resp_data", resp_data0, 16'h0000);
    chk("midrst_resp_err", resp_err0, 1'b0);
    sb0.delete();
    nedge();
    rst_n = 1'b1;
    do_req0(1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0);

    // LATENCY 1, request held valid: stores, loads back, then a misaligned load
    k = 0; t = 0; prev_acc = 0;
    while (k < 9 && t < 200) begin
      nedge();
      t++;
      if (req_ready1) begin
        if (k < 4) begin
          w = 1'b1; a = 16'(2 * k); d = 16'hC000 + 16'(k); ed = d; ee = 1'b0;
        end else if (k < 8) begin
          w = 1'b0; a = 16'(2 * (7 - k)); d = 16'hFFFF; ed = 16'hC000 + 16'(7 - k); ee = 1'b0;
        end else begin
          w = 1'b0; a = 16'h0003; d = 16'hFFFF; ed = 16'h0000; ee = 1'b1;
        end
        req_wr1 = w; req_addr1 = a; req_data1 = d; req_valid1 = 1'b1;
        sb1.push_back('{data: ed, err: ee, acc: cyc + 1});
        if (k > 0) chk("acc_gap1", cyc + 1 - prev_acc, 3);
        prev_acc = cyc + 1;
        k++;
      end
    end
    chk("b2b_timeout", k, 9);
    nedge();
    req_valid1 = 1'b0;
    t = 0;
    while (sb1.size() != 0 && t < 50) begin
      nedge();
      t++;
    end
    chk("resp1_timeout", sb1.size(), 0);

    repeat (3) nedge();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data memory that acts as the responder side of a valid/ready load/store request interface issued by the CPU core.
- Accepts one request at a time and holds it for a programmable latency.
- Performs the word read or write, then returns a response that is held until the requester accepts it.
- Replaces the single-cycle data memory when the core moves to stall-on-memory operation.

Parameters:
- ADDR_WIDTH, 8: number of word-index bits; storage depth is 2^ADDR_WIDTH 16-bit words.
- LATENCY, 4: number of clock edges from request acceptance to resp_valid rising. Legal range is 1 to 15.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- req_valid, input, 1: requester has a request on req_wr, req_addr and req_data.
- req_ready, output, 1: responder can accept a request this cycle.
- req_wr, input, 1: 1 means store, 0 means load.
- req_addr, input, 16: byte address; word index is req_addr[ADDR_WIDTH:1].
- req_data, input, 16: store data.
- resp_valid, output, 1: response available.
- resp_ready, input, 1: requester accepts the response this cycle.
- resp_data, output, 16: load data; for a store, the data that was written.
- resp_err, output, 1: request was misaligned; no access was performed.

Behaviour:
- States are IDLE, BUSY and RESP, with a 4-bit down-counter.
- req_ready = (state == IDLE), decoded combinationally from state only.
- resp_valid = (state == RESP), decoded combinationally from state only.
- Reset (rst_n low, asynchronous):
  - state goes to IDLE and the counter to 0.
  - resp_data = 16'h0000 and resp_err = 0.
  - As a result req_ready = 1 and resp_valid = 0 during and after reset.
  - Storage contents are not reset and are preserved across reset.
- IDLE:
  - On an edge with req_valid && req_ready, latch req_wr, req_addr and req_data.
  - Load counter with LATENCY-1 and go to BUSY.
  - With req_valid low, remain in IDLE with no side effects.
- BUSY:
  - req_ready = 0, so request inputs are ignored and need not be held stable.
  - Each edge: if counter != 0, decrement; if counter == 0, perform the access and go to RESP.
  - Net effect: a request accepted at edge N gives resp_valid high after edge N+LATENCY.
- Access (completion edge):
  - Misaligned (latched addr[0] = 1): no memory access, resp_err <= 1, resp_data <= 0.
  - Aligned store: mem[idx] <= latched data, resp_data <= latched data, resp_err <= 0.
  - Aligned load: resp_data <= mem[idx] (the value before this edge), resp_err <= 0.
  - Address bits above ADDR_WIDTH are ignored, so addresses alias modulo 2^(ADDR_WIDTH+1) bytes.
- RESP:
  - resp_valid = 1; resp_data and resp_err are held stable until the handshake.
  - An edge with resp_ready = 1 returns the block to IDLE.
  - resp_ready may be held high in advance, giving zero stall.
  - A new request can be accepted only from IDLE, so there is at least one idle cycle between responses. The block never has more than one request outstanding.
- After the handshake, resp_data and resp_err keep their last values until the next completion edge.
- resp_ready while not in RESP is ignored.
- Reset mid-operation:
  - A store still in BUSY is dropped and memory is unchanged.
  - A pending RESP is discarded, with resp_valid going low asynchronously.
- LATENCY = 1: BUSY lasts exactly one edge (counter starts at 0).

Test Plan:
- Reset, then store 16'hBEEF to address 16'h0010 with LATENCY = 4 and resp_ready held at 1 → req_ready falls the cycle after acceptance; resp_valid is high exactly 4 edges after acceptance for one cycle; resp_data = BEEF, resp_err = 0; req_ready returns to 1 the following cycle.
- Load from 16'h0010 → resp_data = BEEF after 4 edges. Then load from 16'h0210 with ADDR_WIDTH = 8 → aliases to the same word and returns BEEF.
- Store 16'h1234 to odd address 16'h0011 → resp_err = 1, resp_data = 0, and a subsequent load of 16'h0010 still returns BEEF.
- Hold resp_ready at 0 for 5 cycles during RESP → resp_valid, resp_data and resp_err stay stable; req_valid is ignored (req_ready = 0); the handshake completes on the first edge with resp_ready = 1.
- Accept a store of 16'hAAAA to 16'h0020, then pulse rst_n low 2 edges after acceptance → outputs return to reset values immediately; a later load of 16'h0020 returns the prior contents, not AAAA.
- LATENCY = 1: run back-to-back loads with req_valid held at 1 and resp_ready at 1 → each response arrives 1 edge after its acceptance; accepts occur every 3 cycles.
